// File: rtl/dual_port_ram.sv
// Single-clock 16x8 RAM: port 0 writes or reads, port 1 reads only.
// Read-first on same-address collision; async active-high reset clears array and outputs.
module dual_port_ram #(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 8,
    parameter int unsigned depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [data_width-1:0] data_in,
    input  logic [addr_width-1:0] addr_in_0,
    input  logic [addr_width-1:0] addr_in_1,
    input  logic                  port_en_0,
    input  logic                  port_en_1,
    output logic [data_width-1:0] data_out_0,
    output logic [data_width-1:0] data_out_1
);

    logic [data_width-1:0] r_mem [depth];
    logic [data_width-1:0] r_data_out_0;
    logic [data_width-1:0] r_data_out_1;
    logic                  w_wr;
    logic                  w_rd_0;

    assign w_wr   = port_en_0 & wr_en;
    assign w_rd_0 = port_en_0 & ~wr_en;

    // Array storage; the whole array is cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[addr_in_0] <= data_in;
        end
    end

    // Read registers sample the pre-write contents, giving read-first collisions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out_0 <= '0;
            r_data_out_1 <= '0;
        end else begin
            if (w_rd_0) begin
                r_data_out_0 <= r_mem[addr_in_0];
            end
            if (port_en_1) begin
                r_data_out_1 <= r_mem[addr_in_1];
            end
        end
    end

    assign data_out_0 = r_data_out_0;
    assign data_out_1 = r_data_out_1;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: directed and random steps against
// an array-based reference model of the RAM behaviour.
module tb_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic [3:0] addr_in_0;
    logic [3:0] addr_in_1;
    logic       port_en_0;
    logic       port_en_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mem_m [16];
    logic [7:0] exp0;
    logic [7:0] exp1;

    dual_port_ram #(.addr_width(4), .data_width(8), .depth(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .addr_in_0  (addr_in_0),
        .addr_in_1  (addr_in_1),
        .port_en_0  (port_en_0),
        .port_en_1  (port_en_1),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        exp0 = 8'h00;
        exp1 = 8'h00;
    endtask

    // Evaluate one clock edge in the model, then advance the DUT and compare
    task automatic step(input string tag);
        if (!rst) begin
            if (port_en_1) exp1 = mem_m[addr_in_1];
            if (port_en_0 && !wr_en) exp0 = mem_m[addr_in_0];
            if (port_en_0 && wr_en) mem_m[addr_in_0] = data_in;
        end
        @(posedge clk);
        #1;
        check({tag, "_p0"}, data_out_0, exp0);
        check({tag, "_p1"}, data_out_1, exp1);
    endtask

    task automatic idle();
        wr_en = 1'b0; port_en_0 = 1'b0; port_en_1 = 1'b0;
        data_in = 8'h00; addr_in_0 = 4'h0; addr_in_1 = 4'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_clear();
        #2;
        check("reset_init_p0", data_out_0, 8'h00);
        check("reset_init_p1", data_out_1, 8'h00);
        step("reset_hold");
        rst = 1'b0;

        // Random prior contents
        for (int i = 0; i < 24; i++) begin
            port_en_0 = 1'b1; wr_en = 1'($urandom);
            addr_in_0 = 4'($urandom); data_in = 8'($urandom);
            port_en_1 = 1'($urandom); addr_in_1 = 4'($urandom);
            step("prefill");
        end
        idle();

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check("async_rst_p0", data_out_0, 8'h00);
        check("async_rst_p1", data_out_1, 8'h00);
        step("rst_held");
        rst = 1'b0;
        port_en_1 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            addr_in_1 = 4'(a);
            step("post_rst_sweep");
            check("post_rst_zero", data_out_1, 8'h00);
        end
        idle();

        // Fill: value i at address i-1
        for (int i = 1; i <= 16; i++) begin
            port_en_0 = 1'b1; wr_en = 1'b1;
            addr_in_0 = 4'(i - 1); data_in = 8'(i);
            step("fill");
        end
        idle();
        port_en_1 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            addr_in_1 = 4'(a);
            step("readback");
            check("readback_const", data_out_1, 8'(a + 1));
        end
        idle();

        // Port 0 read, then output holds across a write
        port_en_0 = 1'b1; wr_en = 1'b0; addr_in_0 = 4'd5;
        step("p0_read");
        check("p0_read5", data_out_0, 8'd6);
        wr_en = 1'b1; addr_in_0 = 4'd5; data_in = 8'd6;
        step("p0_hold_on_write");
        check("p0_hold_const", data_out_0, 8'd6);

        // Write ignored when port 0 disabled
        port_en_0 = 1'b0; wr_en = 1'b1; addr_in_0 = 4'd3; data_in = 8'hAA;
        step("gated_write");
        idle();
        port_en_1 = 1'b1; addr_in_1 = 4'd3;
        step("gated_readback");
        check("gated_mem3", data_out_1, 8'd4);
        port_en_1 = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr_in_1 = 4'(a + 9);
            step("p1_hold");
            check("p1_hold_const", data_out_1, 8'd4);
        end

        // Read-first collision at address 7
        port_en_0 = 1'b1; wr_en = 1'b1; addr_in_0 = 4'd7; data_in = 8'h55;
        port_en_1 = 1'b1; addr_in_1 = 4'd7;
        step("collision");
        check("collision_old", data_out_1, 8'd8);
        idle();
        port_en_1 = 1'b1; addr_in_1 = 4'd7;
        step("collision_next");
        check("collision_new", data_out_1, 8'h55);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            port_en_0 = 1'($urandom); wr_en = 1'($urandom);
            addr_in_0 = 4'($urandom); data_in = 8'($urandom);
            port_en_1 = 1'($urandom);
            addr_in_1 = ($urandom_range(0, 3) == 0) ? addr_in_0 : 4'($urandom);
            step("random");
        end
        idle();

        // Reset in the middle of a readback sweep
        port_en_1 = 1'b1;
        for (int a = 0; a < 6; a++) begin
            addr_in_1 = 4'(a);
            step("mid_sweep");
        end
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check("mid_rst_p0", data_out_0, 8'h00);
        check("mid_rst_p1", data_out_1, 8'h00);
        port_en_0 = 1'b1; wr_en = 1'b1; addr_in_0 = 4'd2; data_in = 8'hEE;
        step("write_blocked_in_rst");
        rst = 1'b0;
        idle();
        port_en_0 = 1'b1; port_en_1 = 1'b1;
        for (int a = 0; a < 16; a++) begin
            addr_in_0 = 4'(15 - a);
            addr_in_1 = 4'(a);
            step("post_mid_rst");
            check("post_mid_rst_p0", data_out_0, 8'h00);
            check("post_mid_rst_p1", data_out_1, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
